// File: rtl/rotary_input_filter_debounce_channel.sv
// One quadrature contact: two-flop synchroniser, stability counter, filtered
// level and a registered single-cycle change strobe aligned with that level.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o,
  output logic chg_o,
  output logic chg_next_o
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             filt_q, filt_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      chg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any cycle of agreement clears the count, so only an uninterrupted run of
  // DEBOUNCE_CYCLES disagreeing samples moves the filtered level.
  always_comb begin
    filt_d = filt_q;
    chg_d  = 1'b0;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = s2_q;
        chg_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign filt_o     = filt_q;
  assign chg_o      = chg_q;
  assign chg_next_o = chg_d;

endmodule

// File: rtl/rotary_input_filter.sv
// Input conditioning for the rotary encoder: debounces both quadrature contacts
// and flags the illegal case of both filtered levels changing on one edge.
module rotary_input_filter #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rot_a,
  input  logic rot_b,
  output logic rot_a_f,
  output logic rot_b_f,
  output logic a_chg,
  output logic b_chg,
  output logic illegal
);

  logic a_chg_next, b_chg_next;
  logic illegal_q, illegal_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     (rot_a),
    .filt_o    (rot_a_f),
    .chg_o     (a_chg),
    .chg_next_o(a_chg_next)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     (rot_b),
    .filt_o    (rot_b_f),
    .chg_o     (b_chg),
    .chg_next_o(b_chg_next)
  );

  // Built from the next-state strobes so it lands in the same cycle as a_chg/b_chg.
  assign illegal_d = a_chg_next & b_chg_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;

endmodule
